// File: rtl/neuron_mac_seq.sv
// Sequences one shared 8-bit signed multiplier over N buffered X/W pairs,
// accumulating BIAS + sum(X*W) with saturation, then applies the activation.
module neuron_mac_seq #(
  parameter int AW    = 4,
  parameter int ACC_W = 16,
  parameter int RELU  = 0
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          START,
  input  logic          ABORT,
  input  logic [AW:0]   N_TERMS,
  input  logic [7:0]    BIAS,
  output logic          RD_EN,
  output logic [AW-1:0] ADDR,
  input  logic [7:0]    X_IN,
  input  logic [7:0]    W_IN,
  output logic [7:0]    MPY_A,
  output logic [7:0]    MPY_B,
  input  logic [7:0]    MPY_P,
  output logic          BUSY,
  output logic          DONE,
  output logic [7:0]    Y
);

  localparam int MAX_N = 2 ** AW;
  localparam logic [AW:0] MAX_NV = (AW+1)'(MAX_N);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] ACC_MAX = ~ACC_MIN;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t state, state_nx;

  logic [AW:0]      n_q;
  logic [AW:0]      cnt;
  logic [ACC_W-1:0] acc;
  logic             pipe_v;
  logic [7:0]       y_q;
  logic             done_q;

  logic [AW:0]      n_start;
  logic [ACC_W-1:0] bias_ext;
  logic [ACC_W:0]   sum;
  logic [ACC_W-1:0] acc_nx;

  function automatic logic [7:0] sat8(input logic [ACC_W-1:0] v);
    logic [ACC_W-8:0] top;
    top = v[ACC_W-1:7];
    if (&top || ~|top) return v[7:0];
    return v[ACC_W-1] ? 8'h80 : 8'h7f;
  endfunction

  function automatic logic [7:0] act(input logic [7:0] v);
    return (RELU != 0 && v[7]) ? 8'h00 : v;
  endfunction

  assign n_start  = (N_TERMS > MAX_NV) ? MAX_NV : N_TERMS;
  assign bias_ext = {{(ACC_W-8){BIAS[7]}}, BIAS};

  // One guard bit catches overflow; clamp instead of wrapping.
  assign sum = {acc[ACC_W-1], acc}
             + {{(ACC_W-7){MPY_P[7]}}, MPY_P};
  assign acc_nx = (sum[ACC_W] != sum[ACC_W-1])
                ? (sum[ACC_W] ? ACC_MIN : ACC_MAX)
                : sum[ACC_W-1:0];

  assign RD_EN = (state == RUN);
  assign ADDR  = RD_EN ? cnt[AW-1:0] : '0;
  assign BUSY  = (state != IDLE);
  assign MPY_A = pipe_v ? X_IN : 8'h00;
  assign MPY_B = pipe_v ? W_IN : 8'h00;
  assign DONE  = done_q;
  assign Y     = y_q;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (START && n_start != '0) state_nx = RUN;
      RUN: begin
        if (ABORT) state_nx = IDLE;
        else if (cnt == n_q - ONE) state_nx = DRAIN;
      end
      DRAIN: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state <= IDLE;
    else state <= state_nx;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      n_q    <= '0;
      cnt    <= '0;
      acc    <= '0;
      pipe_v <= 1'b0;
      y_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (START) begin
            n_q <= n_start;
            acc <= bias_ext;
            cnt <= '0;
            if (n_start == '0) begin
              y_q    <= act(BIAS);
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (ABORT) begin
            pipe_v <= 1'b0;
          end else begin
            cnt    <= cnt + ONE;
            pipe_v <= 1'b1;
            if (pipe_v) acc <= acc_nx;
          end
        end
        DRAIN: begin
          pipe_v <= 1'b0;
          if (!ABORT) begin
            acc    <= acc_nx;
            y_q    <= act(sat8(acc_nx));
            done_q <= 1'b1;
          end
        end
        default: pipe_v <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_seq.sv
// Bench for neuron_mac_seq: table vectors, hand sequences for abort/reset,
// and random runs against an arithmetic reference model.
module tb_neuron_mac_seq;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       START = 1'b0;
  logic       ABORT = 1'b0;
  logic [4:0] N_TERMS = '0;
  logic [7:0] BIAS = '0;
  logic [7:0] X_IN = '0;
  logic [7:0] W_IN = '0;

  logic       rd_en, busy, done;
  logic [3:0] addr;
  logic [7:0] mpy_a, mpy_b, mpy_p, y;
  logic       rd_en_r, busy_r, done_r;
  logic [3:0] addr_r;
  logic [7:0] mpy_a_r, mpy_b_r, mpy_p_r, y_r;

  logic [7:0] xm [16];
  logic [7:0] wm [16];

  int tests = 0;
  int fails = 0;
  int lat, reads, addr_bad, busy_bad;

  typedef struct {
    int nt;
    int bias;
    int x0, x1, x2, xf;
    int w0, w1, w2, wf;
    int ey;
    int eyr;
  } vec_t;

  vec_t tv [8];

  always #5 CLK = ~CLK;

  // External multiplier: signed product truncated to 8 bits.
  function automatic logic [7:0] mpy8(input logic [7:0] a,
                                      input logic [7:0] b);
    logic signed [15:0] p;
    p = $signed(a) * $signed(b);
    return p[7:0];
  endfunction

  function automatic int sx8(input logic [7:0] v);
    return int'($signed(v));
  endfunction

  assign mpy_p   = mpy8(mpy_a, mpy_b);
  assign mpy_p_r = mpy8(mpy_a_r, mpy_b_r);

  always @(posedge CLK) begin
    if (rd_en) begin
      X_IN <= xm[addr];
      W_IN <= wm[addr];
    end
  end

  neuron_mac_seq #(.AW(4), .ACC_W(16), .RELU(0)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
    .N_TERMS(N_TERMS), .BIAS(BIAS), .RD_EN(rd_en), .ADDR(addr),
    .X_IN(X_IN), .W_IN(W_IN), .MPY_A(mpy_a), .MPY_B(mpy_b),
    .MPY_P(mpy_p), .BUSY(busy), .DONE(done), .Y(y)
  );

  neuron_mac_seq #(.AW(4), .ACC_W(9), .RELU(1)) dut_r (
    .CLK(CLK), .RST_N(RST_N), .START(START), .ABORT(ABORT),
    .N_TERMS(N_TERMS), .BIAS(BIAS), .RD_EN(rd_en_r), .ADDR(addr_r),
    .X_IN(X_IN), .W_IN(W_IN), .MPY_A(mpy_a_r), .MPY_B(mpy_b_r),
    .MPY_P(mpy_p_r), .BUSY(busy_r), .DONE(done_r), .Y(y_r)
  );

  function automatic int model_y(input int n, input int bias,
                                 input int accw, input bit relu);
    int lo, hi, acc, yv;
    lo = -(1 << (accw - 1));
    hi = (1 << (accw - 1)) - 1;
    acc = bias;
    for (int k = 0; k < n; k++) begin
      acc += sx8(mpy8(xm[k], wm[k]));
      if (acc > hi) acc = hi;
      if (acc < lo) acc = lo;
    end
    yv = acc > 127 ? 127 : (acc < -128 ? -128 : acc);
    if (relu && yv < 0) yv = 0;
    return yv;
  endfunction

  task automatic check(input string nm, input int got, input int exp);
    tests++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic load(input vec_t v);
    for (int k = 0; k < 16; k++) begin
      xm[k] = 8'(k == 0 ? v.x0 : k == 1 ? v.x1 : k == 2 ? v.x2 : v.xf);
      wm[k] = 8'(k == 0 ? v.w0 : k == 1 ? v.w1 : k == 2 ? v.w2 : v.wf);
    end
  endtask

  task automatic run_op(input int nt, input int bias,
                        input bit poke, input bit ab);
    @(negedge CLK);
    START = 1'b1;
    ABORT = ab;
    N_TERMS = nt[4:0];
    BIAS = bias[7:0];
    @(posedge CLK);
    #1;
    START = 1'b0;
    ABORT = 1'b0;
    N_TERMS = 5'd9;
    BIAS = 8'h55;
    lat = 0;
    reads = 0;
    addr_bad = 0;
    busy_bad = 0;
    @(negedge CLK);
    while (!done && lat < 200) begin
      if (rd_en) begin
        if (int'(addr) != reads) addr_bad++;
        reads++;
      end
      if (!busy) busy_bad++;
      START = poke && lat == 1;
      lat++;
      @(negedge CLK);
    end
    START = 1'b0;
  endtask

  task automatic check_op(input string tag, input int nt, input int bias,
                          input int ey, input int eyr,
                          input bit poke, input bit ab);
    int n;
    n = nt > 16 ? 16 : nt;
    run_op(nt, bias, poke, ab);
    check({tag, ".y"}, sx8(y), ey);
    check({tag, ".y_relu"}, sx8(y_r), eyr);
    check({tag, ".done_r"}, int'(done_r), 1);
    check({tag, ".latency"}, lat, n == 0 ? 0 : n + 1);
    check({tag, ".reads"}, reads, n);
    check({tag, ".addr_seq"}, addr_bad, 0);
    check({tag, ".busy_run"}, busy_bad, 0);
    check({tag, ".busy_at_done"}, int'(busy), 0);
    @(negedge CLK);
    check({tag, ".done_pulse"}, int'(done), 0);
  endtask

  initial begin
    int prev, ndone, nt, bias, n;

    tv[0] = '{3, 0, 3, 4, 13, 0, 5, 2, -1, 0, 10, 10};
    tv[1] = '{2, 1, -5, 6, 0, 0, -2, -2, 0, 0, -1, 0};
    tv[2] = '{8, 0, 10, 10, 10, 10, 10, 10, 10, 10, 127, 127};
    tv[3] = '{8, 0, -10, -10, -10, -10, 10, 10, 10, 10, -128, 0};
    tv[4] = '{0, -7, 1, 1, 1, 1, 1, 1, 1, 1, -7, 0};
    tv[5] = '{31, 0, 1, 1, 1, 1, 1, 1, 1, 1, 16, 16};
    tv[6] = '{1, 100, 100, 0, 0, 0, 1, 0, 0, 0, 127, 127};
    tv[7] = '{16, -128, -100, -100, -100, -100, 1, 1, 1, 1, -128, 0};

    repeat (2) @(negedge CLK);
    check("rst.y", int'(y), 0);
    check("rst.ctl", int'({rd_en, addr, busy, done}), 0);
    RST_N = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 8; i++) begin
      load(tv[i]);
      check_op($sformatf("vec%0d", i), tv[i].nt, tv[i].bias,
               tv[i].ey, tv[i].eyr, 1'b0, 1'b0);
    end

    load(tv[2]);
    check_op("start_midrun", 8, 0, 127, 127, 1'b1, 1'b0);
    load(tv[0]);
    check_op("abort_with_start", 3, 0, 10, 10, 1'b0, 1'b1);

    prev = sx8(y);
    load(tv[2]);
    @(negedge CLK);
    START = 1'b1;
    N_TERMS = 5'd5;
    BIAS = 8'd3;
    @(posedge CLK);
    #1;
    START = 1'b0;
    @(negedge CLK);
    ABORT = 1'b1;
    @(posedge CLK);
    #1;
    ABORT = 1'b0;
    @(negedge CLK);
    check("abort.idle", int'({busy, rd_en, mpy_a, mpy_b}), 0);
    ndone = 0;
    repeat (12) begin
      @(negedge CLK);
      if (done) ndone++;
    end
    check("abort.no_done", ndone, 0);
    check("abort.y_hold", sx8(y), prev);

    @(negedge CLK);
    START = 1'b1;
    N_TERMS = 5'd6;
    BIAS = 8'd0;
    @(posedge CLK);
    #1;
    START = 1'b0;
    repeat (3) @(negedge CLK);
    RST_N = 1'b0;
    #1;
    check("rst_mid.outs",
          int'({rd_en, addr, busy, done, y, mpy_a, mpy_b}), 0);
    @(negedge CLK);
    RST_N = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge CLK);
      if (done) ndone++;
    end
    check("rst_mid.no_done", ndone, 0);
    load(tv[0]);
    check_op("after_rst", 3, 0, 10, 10, 1'b0, 1'b0);

    for (int it = 0; it < 25; it++) begin
      nt = int'($urandom_range(0, 20));
      bias = sx8(8'($urandom));
      for (int k = 0; k < 16; k++) begin
        xm[k] = 8'($urandom);
        wm[k] = 8'($urandom);
      end
      n = nt > 16 ? 16 : nt;
      check_op($sformatf("rnd%0d", it), nt, bias,
               model_y(n, bias, 16, 1'b0),
               model_y(n, bias, 9, 1'b1), 1'b0, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
